// File: rtl/age_ordered_rs.sv
// Age-ordered reservation station: buffers dispatched ops, captures CDB results and issues the oldest ready entry.
// Optional macro RS_BYPASS_EN lets a fully ready dispatch load the issue register directly when nothing is ready.
module age_ordered_rs #(
    parameter int DEPTH   = 16,
    parameter int NUM_CDB = 2,
    parameter int TAG_W   = 5,
    parameter int OP_W    = 6,
    parameter int XLEN    = 32
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       rdy_in,
    input  logic                       rollback_in,
    input  logic                       disp_valid,
    input  logic [OP_W-1:0]            disp_op,
    input  logic [TAG_W-1:0]           disp_q1,
    input  logic [TAG_W-1:0]           disp_q2,
    input  logic [XLEN-1:0]            disp_v1,
    input  logic [XLEN-1:0]            disp_v2,
    input  logic [XLEN-1:0]            disp_pc,
    input  logic [XLEN-1:0]            disp_imm,
    input  logic [TAG_W-1:0]           disp_rob_id,
    output logic                       disp_ready,
    input  logic [NUM_CDB-1:0]         cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]   cdb_tag,
    input  logic [NUM_CDB*XLEN-1:0]    cdb_data,
    output logic                       issue_valid,
    input  logic                       issue_ready,
    output logic [OP_W-1:0]            issue_op,
    output logic [XLEN-1:0]            issue_v1,
    output logic [XLEN-1:0]            issue_v2,
    output logic [XLEN-1:0]            issue_pc,
    output logic [XLEN-1:0]            issue_imm,
    output logic [TAG_W-1:0]           issue_rob_id,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] busy;
    logic [OP_W-1:0]  e_op  [DEPTH];
    logic [TAG_W-1:0] e_q1  [DEPTH];
    logic [TAG_W-1:0] e_q2  [DEPTH];
    logic [XLEN-1:0]  e_v1  [DEPTH];
    logic [XLEN-1:0]  e_v2  [DEPTH];
    logic [XLEN-1:0]  e_pc  [DEPTH];
    logic [XLEN-1:0]  e_imm [DEPTH];
    logic [TAG_W-1:0] e_rob [DEPTH];
    // age[i][j] set means entry i is older than entry j
    logic [DEPTH-1:0] age   [DEPTH];

    logic [TAG_W-1:0] wake_q1 [DEPTH];
    logic [TAG_W-1:0] wake_q2 [DEPTH];
    logic [XLEN-1:0]  wake_v1 [DEPTH];
    logic [XLEN-1:0]  wake_v2 [DEPTH];
    logic [TAG_W-1:0] fwd_q1, fwd_q2;
    logic [XLEN-1:0]  fwd_v1, fwd_v2;
    logic [DEPTH-1:0] ready, oldest;
    logic             any_ready;
    logic [IDX_W-1:0] sel_idx, free_idx;
    logic [CNT_W-1:0] busy_cnt;
    logic             can_load, disp_fire, bypass, alloc, load_entry;

    // Channels scanned high to low so the lowest matching channel has the final say.
    always_comb begin
        fwd_q1 = disp_q1;
        fwd_v1 = disp_v1;
        fwd_q2 = disp_q2;
        fwd_v2 = disp_v2;
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
            if (cdb_valid[k] && disp_q1 != '0 && cdb_tag[k*TAG_W +: TAG_W] == disp_q1) begin
                fwd_q1 = '0;
                fwd_v1 = cdb_data[k*XLEN +: XLEN];
            end
            if (cdb_valid[k] && disp_q2 != '0 && cdb_tag[k*TAG_W +: TAG_W] == disp_q2) begin
                fwd_q2 = '0;
                fwd_v2 = cdb_data[k*XLEN +: XLEN];
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            wake_q1[i] = e_q1[i];
            wake_v1[i] = e_v1[i];
            wake_q2[i] = e_q2[i];
            wake_v2[i] = e_v2[i];
            for (int k = NUM_CDB - 1; k >= 0; k--) begin
                if (cdb_valid[k] && e_q1[i] != '0 && cdb_tag[k*TAG_W +: TAG_W] == e_q1[i]) begin
                    wake_q1[i] = '0;
                    wake_v1[i] = cdb_data[k*XLEN +: XLEN];
                end
                if (cdb_valid[k] && e_q2[i] != '0 && cdb_tag[k*TAG_W +: TAG_W] == e_q2[i]) begin
                    wake_q2[i] = '0;
                    wake_v2[i] = cdb_data[k*XLEN +: XLEN];
                end
            end
        end
    end

    // Selection looks only at registered tags; a same-cycle wakeup issues one cycle later.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ready[i] = busy[i] && e_q1[i] == '0 && e_q2[i] == '0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            oldest[i] = ready[i];
            for (int k = 0; k < DEPTH; k++) begin
                if (ready[k] && age[k][i]) oldest[i] = 1'b0;
            end
        end
        any_ready = |ready;
        sel_idx   = '0;
        free_idx  = '0;
        busy_cnt  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (oldest[i]) sel_idx = IDX_W'(i);
            if (!busy[i]) free_idx = IDX_W'(i);
        end
        for (int i = 0; i < DEPTH; i++) begin
            busy_cnt = busy_cnt + CNT_W'(busy[i]);
        end
    end

    assign count      = busy_cnt;
    assign disp_ready = ~&busy;
    assign can_load   = !issue_valid || issue_ready;
    assign disp_fire  = disp_valid && disp_ready;
    assign load_entry = any_ready && can_load;

`ifdef RS_BYPASS_EN
    assign bypass = disp_fire && fwd_q1 == '0 && fwd_q2 == '0 && !any_ready && can_load;
`else
    assign bypass = 1'b0;
`endif

    assign alloc = disp_fire && !bypass;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy         <= '0;
            issue_valid  <= 1'b0;
            issue_op     <= '0;
            issue_v1     <= '0;
            issue_v2     <= '0;
            issue_pc     <= '0;
            issue_imm    <= '0;
            issue_rob_id <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                age[i]   <= '0;
                e_op[i]  <= '0;
                e_q1[i]  <= '0;
                e_q2[i]  <= '0;
                e_v1[i]  <= '0;
                e_v2[i]  <= '0;
                e_pc[i]  <= '0;
                e_imm[i] <= '0;
                e_rob[i] <= '0;
            end
        end else if (rdy_in) begin
            if (rollback_in) begin
                busy        <= '0;
                issue_valid <= 1'b0;
                for (int i = 0; i < DEPTH; i++) age[i] <= '0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (busy[i]) begin
                        e_q1[i] <= wake_q1[i];
                        e_v1[i] <= wake_v1[i];
                        e_q2[i] <= wake_q2[i];
                        e_v2[i] <= wake_v2[i];
                    end
                end
                // New entry is younger than everything currently busy.
                if (alloc) begin
                    busy[free_idx]  <= 1'b1;
                    e_op[free_idx]  <= disp_op;
                    e_q1[free_idx]  <= fwd_q1;
                    e_q2[free_idx]  <= fwd_q2;
                    e_v1[free_idx]  <= fwd_v1;
                    e_v2[free_idx]  <= fwd_v2;
                    e_pc[free_idx]  <= disp_pc;
                    e_imm[free_idx] <= disp_imm;
                    e_rob[free_idx] <= disp_rob_id;
                    age[free_idx]   <= '0;
                    for (int j = 0; j < DEPTH; j++) age[j][free_idx] <= busy[j];
                end
                if (load_entry) begin
                    busy[sel_idx] <= 1'b0;
                    issue_valid   <= 1'b1;
                    issue_op      <= e_op[sel_idx];
                    issue_v1      <= e_v1[sel_idx];
                    issue_v2      <= e_v2[sel_idx];
                    issue_pc      <= e_pc[sel_idx];
                    issue_imm     <= e_imm[sel_idx];
                    issue_rob_id  <= e_rob[sel_idx];
                end else if (bypass) begin
                    issue_valid  <= 1'b1;
                    issue_op     <= disp_op;
                    issue_v1     <= fwd_v1;
                    issue_v2     <= fwd_v2;
                    issue_pc     <= disp_pc;
                    issue_imm    <= disp_imm;
                    issue_rob_id <= disp_rob_id;
                end else if (issue_ready) begin
                    issue_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/age_ordered_rs.md
# age_ordered_rs

Parametrised reservation station for the out-of-order EXE stage. It buffers dispatched instructions and captures operand results from `NUM_CDB` common-data-bus channels. It issues the oldest operand-ready entry to the ALU through a registered valid/ready port that can be stalled, and it is flushed on ROB rollback.

## Interface
Parameters:
- `DEPTH`, 16: entry count, ≥2.
- `NUM_CDB`, 2: number of broadcast channels.
- `TAG_W`, 5: ROB tag width. Tag 0 means "operand ready".
- `OP_W`, 6: instruction-name width.
- `XLEN`, 32: data width.

Ports:
- `clk_in` in 1: clock.
- `rst_in` in 1: reset, asynchronous, active-high.
- `rdy_in` in 1: global enable. When low, all state holds.
- `rollback_in` in 1: flush request from the ROB.
- `disp_valid` in 1: dispatch request.
- `disp_op` in OP_W, `disp_q1`/`disp_q2` in TAG_W, `disp_v1`/`disp_v2`/`disp_pc`/`disp_imm` in XLEN, `disp_rob_id` in TAG_W: dispatch payload.
- `disp_ready` out 1: at least one free entry this cycle.
- `cdb_valid` in NUM_CDB: one bit per channel.
- `cdb_tag` in NUM_CDB*TAG_W, `cdb_data` in NUM_CDB*XLEN: flattened per channel; channel k occupies slice k.
- `issue_valid` out 1, `issue_ready` in 1: ALU handshake.
- `issue_op` out OP_W, `issue_v1`/`issue_v2`/`issue_pc`/`issue_imm` out XLEN, `issue_rob_id` out TAG_W: issued payload.
- `count` out $clog2(DEPTH+1): number of busy entries.

## Operation
- Each entry holds busy, op, Q1/Q2, V1/V2, pc, imm and rob_id.
- An `DEPTH`×`DEPTH` age matrix records relative age. On insert, the new entry is marked younger than every busy entry.
- Insert:
  - Occurs when `disp_valid && disp_ready`. The target is the lowest-index free entry.
  - `disp_valid` while `!disp_ready` is ignored.
- Same-cycle forwarding on insert: if `disp_qN != 0` matches a valid CDB tag, the entry stores QN=0 and VN=that channel's data.
- Wakeup: each busy entry compares Q1/Q2 against every valid channel. On a match it sets Q=0 and V=data.
  - Tag 0 on the CDB never matches.
  - If several channels carry the same tag, the lowest channel index wins.
- Select: among busy entries with Q1=Q2=0, pick the entry no other ready entry is older than. Selection uses registered Q values only.
- Output register:
  - Loads when `!issue_valid || issue_ready` and a ready entry exists.
  - Loading clears that entry's busy bit. Otherwise `issue_valid` falls on a handshake, or holds with a stable payload.
- `disp_ready` and `count` derive from registered busy bits. A slot freed by issue is not reusable in the same cycle.
- Rollback (synchronous, priority over all other actions): clears every busy bit, the age matrix and `issue_valid`. A concurrent dispatch is dropped.
- When `rdy_in` is low, nothing updates. CDB producers are frozen by the same signal.

## Timing
- Reset values: all busy=0, age matrix=0, `issue_valid`=0, all issue payload outputs=0, `count`=0, `disp_ready`=1.
- Dispatch accepted at edge N → entry busy after N → earliest `issue_valid` after edge N+1. Latency is 2 cycles.
- A CDB broadcast at edge N wakes an entry; that entry can load the output register at edge N+1.
- Full: `count`=DEPTH, `disp_ready`=0.
- Empty with no ready entry: `issue_valid` drops after the handshake edge.
- Reset asserted mid-operation clears state immediately, without waiting for a clock edge.

## Configuration
- `RS_BYPASS_EN` defined: a dispatched instruction may skip entry allocation and load the output register directly (latency 1). All of these must hold:
  - both operands are ready after forwarding;
  - no busy entry is ready;
  - the output register can load this cycle.
- `RS_BYPASS_EN` undefined: every instruction goes through an entry; minimum latency is 2.

## Test plan
- Reset, then dispatch op=ADD, q1=q2=0, v1=5, v2=7, rob_id=3 → `issue_valid` two edges later (one with bypass) with v1=5, v2=7, rob_id=3, `count` back to 0.
- Dispatch A (q1=4) then B (ready) → B issues first. CDB0 tag4 data=0x11 → A issues next with v1=0x11.
- Dispatch with q2=6 while cdb1 valid, tag 6, data 0xAB in the same cycle → entry is ready immediately and issues v2=0xAB.
- Fill 16 entries with q1=9 → `disp_ready`=0, `count`=16, a 17th dispatch is ignored. Wake tag 9 → issues in dispatch order, oldest first.
- Hold `issue_ready`=0 for 5 cycles with `issue_valid`=1 → payload stable and entries retained. Then assert `rollback_in` → next edge `issue_valid`=0, `count`=0.
- Assert `rst_in` between clock edges while 3 entries are busy → `count`=0 and `issue_valid`=0 before the next edge.
